// File: rtl/vend_pkg.sv
// +------------------------------------------------------------------+
// | vend_pkg: FSM states, coin values and 7-segment patterns         |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

package vend_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    VEND     = 3'd1,
    CHANGE   = 3'd2,
    WAIT_ACK = 3'd3,
    DONE     = 3'd4,
    FAULT    = 3'd5
  } state_e;

  localparam int unsigned CROWN_S    = 5;
  localparam int unsigned FLORIN_S   = 2;
  localparam int unsigned SHILLING_S = 1;

  // Active-high segments ordered {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

  function automatic logic [6:0] seg7_pattern(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0:    pat = SEG_0;
      4'h1:    pat = SEG_1;
      4'h2:    pat = SEG_2;
      4'h3:    pat = SEG_3;
      4'h4:    pat = SEG_4;
      4'h5:    pat = SEG_5;
      4'h6:    pat = SEG_6;
      4'h7:    pat = SEG_7;
      4'h8:    pat = SEG_8;
      4'h9:    pat = SEG_9;
      4'hA:    pat = SEG_A;
      4'hB:    pat = SEG_B;
      4'hC:    pat = SEG_C;
      4'hD:    pat = SEG_D;
      4'hE:    pat = SEG_E;
      default: pat = SEG_F;
    endcase
    return pat;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_hex.sv
// +------------------------------------------------------------------+
// | seg7_hex: combinational hex nibble to seven-segment decoder      |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module seg7_hex
  import vend_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = seg7_pattern(nib);

endmodule

`default_nettype wire

// File: rtl/change_dispenser.sv
// +------------------------------------------------------------------+
// | change_dispenser: vend FSM paying change in crowns/florins/bobs  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module change_dispenser
  import vend_pkg::*;
#(
  parameter int CREDIT_W    = 4,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CREDIT_W-1:0] credit,
  input  logic [CREDIT_W-1:0] price,
  input  logic                vend_req,
  input  logic                coin_ack,
  input  logic                clear_fault,
  output logic [6:0]          state_seg,
  output logic [6:0]          change_seg,
  output logic                crown,
  output logic                florin,
  output logic                shilling,
  output logic                dispense,
  output logic                busy,
  output logic                done,
  output logic                err_short,
  output logic                fault
);

  localparam logic [15:0]         TIMEOUT_LAST = 16'(ACK_TIMEOUT - 1);
  localparam logic [CREDIT_W-1:0] CROWN_V      = CREDIT_W'(CROWN_S);
  localparam logic [CREDIT_W-1:0] FLORIN_V     = CREDIT_W'(FLORIN_S);
  localparam logic [CREDIT_W-1:0] SHILLING_V   = CREDIT_W'(SHILLING_S);

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] change_q, change_d;
  logic [15:0]         cnt_q, cnt_d;
  logic                crown_q, crown_d;
  logic                florin_q, florin_d;
  logic                shilling_q, shilling_d;
  logic                dispense_q, dispense_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_short_q, err_short_d;
  logic                fault_q, fault_d;
  logic [CREDIT_W-1:0] coin_val;
  logic [3:0]          change_nib;

  // The presented coin is never larger than change, so the subtraction cannot wrap
  always_comb begin
    coin_val = '0;
    if (crown_q)         coin_val = CROWN_V;
    else if (florin_q)   coin_val = FLORIN_V;
    else if (shilling_q) coin_val = SHILLING_V;
  end

  always_comb begin
    state_d     = state_q;
    change_d    = change_q;
    cnt_d       = cnt_q;
    crown_d     = crown_q;
    florin_d    = florin_q;
    shilling_d  = shilling_q;
    err_short_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (vend_req) begin
          if (credit >= price) begin
            change_d = credit - price;
            state_d  = VEND;
          end else begin
            err_short_d = 1'b1;
          end
        end
      end
      VEND: state_d = CHANGE;
      CHANGE: begin
        if (change_q == '0) begin
          state_d = DONE;
        end else begin
          state_d = WAIT_ACK;
          cnt_d   = '0;
          if (change_q >= CROWN_V)       crown_d    = 1'b1;
          else if (change_q >= FLORIN_V) florin_d   = 1'b1;
          else                           shilling_d = 1'b1;
        end
      end
      WAIT_ACK: begin
        // Ack is tested first so it beats a timeout landing on the same edge
        if (coin_ack) begin
          change_d   = change_q - coin_val;
          crown_d    = 1'b0;
          florin_d   = 1'b0;
          shilling_d = 1'b0;
          state_d    = CHANGE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          crown_d    = 1'b0;
          florin_d   = 1'b0;
          shilling_d = 1'b0;
          state_d    = FAULT;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DONE: state_d = IDLE;
      FAULT: begin
        if (clear_fault) begin
          change_d = '0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    dispense_d = (state_d == VEND);
    done_d     = (state_d == DONE);
    fault_d    = (state_d == FAULT);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      change_q    <= '0;
      cnt_q       <= '0;
      crown_q     <= 1'b0;
      florin_q    <= 1'b0;
      shilling_q  <= 1'b0;
      dispense_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_short_q <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      change_q    <= change_d;
      cnt_q       <= cnt_d;
      crown_q     <= crown_d;
      florin_q    <= florin_d;
      shilling_q  <= shilling_d;
      dispense_q  <= dispense_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_short_q <= err_short_d;
      fault_q     <= fault_d;
    end
  end

  assign change_nib = (state_q == IDLE) ? 4'h0 : change_q[3:0];

  seg7_hex u_state_seg (
    .nib (credit[3:0]),
    .seg (state_seg)
  );

  seg7_hex u_change_seg (
    .nib (change_nib),
    .seg (change_seg)
  );

  assign crown     = crown_q;
  assign florin    = florin_q;
  assign shilling  = shilling_q;
  assign dispense  = dispense_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err_short = err_short_q;
  assign fault     = fault_q;

endmodule

`default_nettype wire

// File: tb/tb_change_dispenser.sv
// +------------------------------------------------------------------+
// | tb_change_dispenser: directed and random vends vs greedy model   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module tb_change_dispenser;

  localparam int CW = 4;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CW-1:0] credit = '0;
  logic [CW-1:0] price = '0;
  logic          vend_req = 1'b0;
  logic          coin_ack = 1'b0;
  logic          clear_fault = 1'b0;
  logic [6:0]    state_seg, change_seg;
  logic          crown, florin, shilling, dispense, busy, done, err_short, fault;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  change_dispenser #(.CREDIT_W(CW), .ACK_TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .credit      (credit),
    .price       (price),
    .vend_req    (vend_req),
    .coin_ack    (coin_ack),
    .clear_fault (clear_fault),
    .state_seg   (state_seg),
    .change_seg  (change_seg),
    .crown       (crown),
    .florin      (florin),
    .shilling    (shilling),
    .dispense    (dispense),
    .busy        (busy),
    .done        (done),
    .err_short   (err_short),
    .fault       (fault)
  );

  function automatic logic [6:0] hex7(input int v);
    case (v & 15)
      0: return 7'h3F;   1: return 7'h06;   2: return 7'h5B;   3: return 7'h4F;
      4: return 7'h66;   5: return 7'h6D;   6: return 7'h7D;   7: return 7'h07;
      8: return 7'h7F;   9: return 7'h6F;   10: return 7'h77;  11: return 7'h7C;
      12: return 7'h39;  13: return 7'h5E;  14: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  function automatic logic [2:0] coin_lines(input int coin);
    if (coin == 5) return 3'b100;
    if (coin == 2) return 3'b010;
    if (coin == 1) return 3'b001;
    return 3'b000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One vend transaction; the expected coin list is the greedy split of credit-price
  task automatic vend(input int c, input int p, input bit extra_req);
    int coins[$];
    int rem;
    int d;
    credit = CW'(c);
    price  = CW'(p);
    vend_req = 1'b1;
    #1 check("state_seg", 32'(state_seg), 32'(hex7(c)));
    tick;
    vend_req = 1'b0;
    if (c < p) begin
      check("err_short_hi", 32'(err_short), 1);
      check("short_busy", 32'(busy), 0);
      check("short_coins", 32'({crown, florin, shilling}), 0);
      check("short_dispense", 32'(dispense), 0);
      tick;
      check("err_short_lo", 32'(err_short), 0);
      check("short_busy2", 32'(busy), 0);
      check("short_coins2", 32'({crown, florin, shilling}), 0);
      return;
    end
    check("dispense_hi", 32'(dispense), 1);
    check("vend_busy", 32'(busy), 1);
    check("vend_change_seg", 32'(change_seg), 32'(hex7(c - p)));
    rem = c - p;
    repeat (rem / 5) coins.push_back(5);
    repeat ((rem % 5) / 2) coins.push_back(2);
    repeat ((rem % 5) % 2) coins.push_back(1);
    tick;
    check("dispense_lo", 32'(dispense), 0);
    check("change_coins_off", 32'({crown, florin, shilling}), 0);
    for (int i = 0; i < coins.size(); i++) begin
      d = int'($urandom_range(0, TO - 1));
      tick;
      check("coin_line", 32'({crown, florin, shilling}), 32'(coin_lines(coins[i])));
      check("wait_change_seg", 32'(change_seg), 32'(hex7(rem)));
      if (extra_req && i == 0) begin
        vend_req = 1'b1;
        price    = '0;
      end
      for (int k = 0; k < d; k++) begin
        tick;
        vend_req = 1'b0;
        price    = CW'(p);
        check("coin_hold", 32'({crown, florin, shilling}), 32'(coin_lines(coins[i])));
        check("no_fault", 32'(fault), 0);
      end
      vend_req = 1'b0;
      price    = CW'(p);
      coin_ack = 1'b1;
      tick;
      coin_ack = 1'b0;
      rem -= coins[i];
      check("coin_drop", 32'({crown, florin, shilling}), 0);
      check("acked_change_seg", 32'(change_seg), 32'(hex7(rem)));
    end
    tick;
    check("done_hi", 32'(done), 1);
    check("done_busy", 32'(busy), 1);
    tick;
    check("done_lo", 32'(done), 0);
    check("idle_busy", 32'(busy), 0);
    check("idle_change_seg", 32'(change_seg), 32'(hex7(0)));
  endtask

  initial begin
    credit = CW'(5);
    #12;
    check("rst_state_seg", 32'(state_seg), 32'(hex7(5)));
    check("rst_change_seg", 32'(change_seg), 32'(hex7(0)));
    check("rst_outputs", 32'({crown, florin, shilling, dispense, busy, done, err_short, fault}), 0);
    @(negedge clk) rst_n = 1'b1;
    tick;

    vend(12, 3, 1'b0);
    vend(3, 5, 1'b0);
    vend(7, 7, 1'b0);
    vend(12, 3, 1'b1);

    // Hopper never acknowledges: timeout, then recovery
    credit = CW'(12);
    price  = CW'(3);
    vend_req = 1'b1;
    tick;
    vend_req = 1'b0;
    tick;
    tick;
    check("to_crown", 32'(crown), 1);
    for (int k = 1; k < TO; k++) begin
      tick;
      check("to_crown_hold", 32'(crown), 1);
      check("to_no_fault", 32'(fault), 0);
    end
    tick;
    check("fault_hi", 32'(fault), 1);
    check("fault_coins", 32'({crown, florin, shilling}), 0);
    check("fault_busy", 32'(busy), 1);
    check("fault_change_held", 32'(change_seg), 32'(hex7(9)));
    coin_ack = 1'b1;
    vend_req = 1'b1;
    tick;
    coin_ack = 1'b0;
    vend_req = 1'b0;
    check("fault_ignores_ack", 32'(fault), 1);
    check("fault_change_held2", 32'(change_seg), 32'(hex7(9)));
    clear_fault = 1'b1;
    tick;
    clear_fault = 1'b0;
    check("cleared_fault", 32'(fault), 0);
    check("cleared_busy", 32'(busy), 0);
    check("cleared_change_seg", 32'(change_seg), 32'(hex7(0)));

    // Asynchronous reset while a crown is being presented
    vend_req = 1'b1;
    tick;
    vend_req = 1'b0;
    tick;
    tick;
    check("pre_rst_crown", 32'(crown), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_crown", 32'(crown), 0);
    check("async_rst_busy", 32'(busy), 0);
    check("async_rst_change_seg", 32'(change_seg), 32'(hex7(0)));
    @(negedge clk) rst_n = 1'b1;
    tick;
    check("post_rst_busy", 32'(busy), 0);
    check("post_rst_coins", 32'({crown, florin, shilling}), 0);
    vend(12, 3, 1'b0);

    for (int t = 0; t < 25; t++) begin
      vend(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 Parameter CREDIT_W, default 4: width of credit, price and change, in shillings; legal range 4..8.
REQ-002 Parameter ACK_TIMEOUT, default 255: number of WAIT_ACK cycles without coin_ack before FAULT; legal range 1..65535.
REQ-003 Port clk  input  1  the block's only clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Port credit  input  CREDIT_W  inserted credit, in shillings.
REQ-006 Port price  input  CREDIT_W  item price, in shillings.
REQ-007 Port vend_req  input  1  vend request, single-cycle pulse.
REQ-008 Port coin_ack  input  1  hopper acknowledges the currently presented coin.
REQ-009 Port clear_fault  input  1  single-cycle pulse; leaves FAULT.
REQ-010 Port state_seg  output  7  seven-segment pattern of credit[3:0].
REQ-011 Port change_seg  output  7  seven-segment pattern of remaining change [3:0].
REQ-012 Port crown  output  1  5-shilling coin request.
REQ-013 Port florin  output  1  2-shilling coin request.
REQ-014 Port shilling  output  1  1-shilling coin request.
REQ-015 Port dispense  output  1  item-dispense pulse.
REQ-016 Port busy  output  1  high in every state except IDLE.
REQ-017 Port done  output  1  vend-complete pulse.
REQ-018 Port err_short  output  1  insufficient-credit pulse.
REQ-019 Port fault  output  1  hopper timeout flag.

Function
REQ-020 FSM states SHALL be IDLE, VEND, CHANGE, WAIT_ACK, DONE, FAULT.
REQ-021 IDLE SHALL, on vend_req with credit>=price, latch change=credit-price and enter VEND on the next edge.
REQ-022 IDLE SHALL, on vend_req with credit<price, pulse err_short for exactly 1 cycle, stay in IDLE and dispense nothing.
REQ-023 VEND SHALL last 1 cycle with dispense=1, then enter CHANGE.
REQ-024 CHANGE SHALL enter DONE when change==0; otherwise it SHALL select the largest coin <=change (5, then 2, then 1) and enter WAIT_ACK.
REQ-025 In WAIT_ACK exactly one coin line SHALL be high (registered, one-hot) until coin_ack is sampled.
REQ-026 On coin_ack in WAIT_ACK, change SHALL decrease by the coin value, the coin line SHALL drop on the same edge, and the next state SHALL be CHANGE.
REQ-027 DONE SHALL last 1 cycle with done=1, then enter IDLE.
REQ-028 A timeout counter SHALL clear on WAIT_ACK entry and increment each WAIT_ACK cycle; at ACK_TIMEOUT without coin_ack the FSM SHALL enter FAULT.
REQ-029 In FAULT: fault=1, all coin lines=0, change held; clear_fault SHALL set change=0 and enter IDLE.
REQ-030 vend_req outside IDLE, coin_ack outside WAIT_ACK, and clear_fault outside FAULT SHALL be ignored.
REQ-031 coin_ack and timeout in the same cycle: the ack SHALL win.
REQ-032 Segment encoding SHALL be {g,f,e,d,c,b,a}, active-high, hex 0-F; change_seg SHALL show 0 when IDLE.
REQ-033 Subtraction SHALL be CREDIT_W wide; underflow SHALL be unreachable by construction.

Reset
REQ-034 rst_n low SHALL immediately force IDLE, change=0, counter=0, and all coin lines, dispense, done, err_short, fault and busy =0, including mid-WAIT_ACK.
REQ-035 On reset, segment outputs SHALL reflect the combinational decode (state_seg=credit, change_seg=0).

Structure
REQ-036 Package vend_pkg SHALL hold the state enum, the coin values (CROWN_S=5, FLORIN_S=2, SHILLING_S=1) and the segment patterns.
REQ-037 A sub-module seg7_hex SHALL be instantiated twice (state, change).

Verification
REQ-038 credit=12, price=3 -> dispense, then crown, florin, florin each acked, change_seg 9->4->2->0, done.
REQ-039 credit=3, price=5 -> err_short 1 cycle, busy stays 0, no coin line toggles.
REQ-040 credit=7, price=7 -> dispense, done 2 cycles later, no coins.
REQ-041 ACK_TIMEOUT=4, no ack -> fault after 4 WAIT_ACK cycles; clear_fault -> IDLE, change_seg=0.
REQ-042 Extra vend_req during WAIT_ACK -> ignored; sequence completes unchanged.
REQ-043 rst_n low during WAIT_ACK with crown=1 -> crown=0 asynchronously, IDLE after release.
